kmkz_dm_ctrl: RTL and testbench

KMKZ_DM_CTRL -- requirements
Module: kmkz_dm_ctrl

---
 rtl/kmkz_dm_ctrl_if.sv | 46 ++++
 rtl/kmkz_dm_ctrl.sv | 156 +++++++++++++++
 tb/tb_kmkz_dm_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kmkz_dm_ctrl_if.sv
// kmkz_dm_ctrl_if -- groups the core-side data-memory handshake and the
// external word-bus signals of kmkz_dm_ctrl.
//
// Signals keep the controller's _i/_o naming, so the direction suffix is
// always read from the controller's point of view.
//   core side : dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i,
//               dm_store_i, dm_ready_o, dm_data_l_o, dm_load_done_o,
//               dm_store_done_o
//   bus side  : bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o, bus_req_o,
//               bus_ack_i, bus_rdata_i, bus_err_o
// Modports:
//   slave  - used by the controller itself
//   master - used by whatever drives the core requests and answers the bus
interface kmkz_dm_ctrl_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic [29:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_req_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    input  bus_ack_i, bus_rdata_i,
    output dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o,
    output bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o, bus_req_o, bus_err_o
  );

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    output bus_ack_i, bus_rdata_i,
    input  dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o,
    input  bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o, bus_req_o, bus_err_o
  );
endinterface

// File: rtl/kmkz_dm_ctrl.sv
// kmkz_dm_ctrl -- data-memory controller between the core's load/store
// port and a simple request/acknowledge word bus.
//
// A request is accepted only in IDLE; address, data and byte enables are
// captured and a single bus transfer is issued. The bus request is held,
// with stable address/data, until the bus acknowledges it or the timeout
// counter expires. Loads return bus_rdata_i (or all ones on a timeout)
// together with a one-cycle dm_load_done_o pulse; stores give a one-cycle
// dm_store_done_o pulse. A timeout also raises the sticky bus_err_o flag,
// which only reset clears.
//
// Parameters:
//   g_timeout - bus-ack timeout in request cycles, 0 disables the timeout
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous reset, active low
//   dm    - kmkz_dm_ctrl_if.slave, core request port and bus port
// Build option:
//   KMKZ_DM_WBUF_EN - posted writes: dm_store_done_o pulses the cycle after
//   a store is accepted and the bus write retires in the background; a
//   timeout on such a write only sets bus_err_o.
module kmkz_dm_ctrl #(
  parameter int unsigned g_timeout = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  kmkz_dm_ctrl_if.slave  dm
);

  // Counter is wide enough for g_timeout, clamped to 8..32 bits.
  localparam int unsigned cnt_bits = $clog2(g_timeout + 1);
  localparam int unsigned cnt_w    = (cnt_bits < 8)  ? 8  :
                                     (cnt_bits > 32) ? 32 : cnt_bits;
  localparam logic [cnt_w-1:0] timeout_last = cnt_w'(g_timeout - 1);

`ifdef KMKZ_DM_WBUF_EN
  localparam bit posted_writes = 1'b1;
`else
  localparam bit posted_writes = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t           state_q;
  logic [cnt_w-1:0] cnt_q;
  logic [29:0]      bus_addr_q;
  logic             bus_we_q;
  logic [3:0]       bus_be_q;
  logic [31:0]      bus_wdata_q;
  logic             bus_req_q;
  logic             bus_err_q;
  logic [31:0]      data_l_q;
  logic             load_done_q;
  logic             store_done_q;
  logic             bus_ack;
  logic             timeout_hit;
  logic             unused_addr_bits;

  // Sub-word address bits never reach the word bus.
  assign unused_addr_bits = ^dm.dm_addr_i[1:0];

  // An ack only counts while a request is actually outstanding.
  assign bus_ack = bus_req_q & dm.bus_ack_i;

  // Counter holds the number of unacknowledged request cycles already
  // completed, so this cycle is the g_timeout-th one when it equals
  // g_timeout-1.
  assign timeout_hit = (g_timeout != 0) && (cnt_q == timeout_last);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bus_addr_q   <= '0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      bus_req_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      data_l_q     <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
    end else begin
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (dm.dm_store_i || dm.dm_load_i) begin
            bus_addr_q  <= dm.dm_addr_i[31:2];
            bus_be_q    <= dm.dm_data_select_i;
            bus_wdata_q <= dm.dm_data_s_i;
            bus_req_q   <= 1'b1;
            // A store wins over a simultaneous load; the load is dropped.
            bus_we_q    <= dm.dm_store_i;
            state_q     <= dm.dm_store_i ? WRITE : READ;
            if (posted_writes && dm.dm_store_i) begin
              store_done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (bus_ack) begin
            data_l_q    <= dm.bus_rdata_i;
            load_done_q <= 1'b1;
            bus_req_q   <= 1'b0;
            state_q     <= IDLE;
          end else if (timeout_hit) begin
            data_l_q    <= 32'hFFFF_FFFF;
            load_done_q <= 1'b1;
            bus_err_q   <= 1'b1;
            bus_req_q   <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          if (bus_ack) begin
            store_done_q <= !posted_writes;
            bus_req_q    <= 1'b0;
            state_q      <= IDLE;
          end else if (timeout_hit) begin
            // A posted write already reported completion; only flag it.
            store_done_q <= !posted_writes;
            bus_err_q    <= 1'b1;
            bus_req_q    <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          bus_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign dm.dm_ready_o      = (state_q == IDLE);
  assign dm.dm_data_l_o     = data_l_q;
  assign dm.dm_load_done_o  = load_done_q;
  assign dm.dm_store_done_o = store_done_q;
  assign dm.bus_addr_o      = bus_addr_q;
  assign dm.bus_we_o        = bus_we_q;
  assign dm.bus_be_o        = bus_be_q;
  assign dm.bus_wdata_o     = bus_wdata_q;
  assign dm.bus_req_o       = bus_req_q;
  assign dm.bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_kmkz_dm_ctrl.sv
// tb_kmkz_dm_ctrl -- directed, scoreboard-checked bench for kmkz_dm_ctrl.
//
// The stimulus thread pushes the hand-computed bus transfer and completion
// it expects for every request; two monitor processes pop those queues when
// the DUT starts a bus request or pulses a done strobe. Cycle-exact timing
// points are checked directly from the stimulus thread. The DUT is built
// with g_timeout=4. Define KMKZ_DM_WBUF_EN for both files to run the
// posted-write variant.
module tb_kmkz_dm_ctrl;

`ifdef KMKZ_DM_WBUF_EN
  localparam bit wbuf = 1'b1;
`else
  localparam bit wbuf = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i;

  always #5 clk = ~clk;

  kmkz_dm_ctrl_if dm_if ();

  kmkz_dm_ctrl #(
    .g_timeout (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .dm    (dm_if)
  );

  typedef struct packed {
    logic        is_load;
    logic [31:0] data;
    logic        err;
  } done_t;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  done_t done_q[$];
  txn_t  txn_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one request for a single cycle; returns in the following cycle.
  task automatic applyStimulus(input logic load, input logic store,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] sel);
    dm_if.dm_load_i        = load;
    dm_if.dm_store_i       = store;
    dm_if.dm_addr_i        = addr;
    dm_if.dm_data_s_i      = data;
    dm_if.dm_data_select_i = sel;
    tick();
    dm_if.dm_load_i  = 1'b0;
    dm_if.dm_store_i = 1'b0;
  endtask

  // Completion monitor.
  initial begin
    done_t d;
    forever begin
      tick();
      if (rst_i === 1'b1 && (dm_if.dm_load_done_o || dm_if.dm_store_done_o)) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done",
                      {30'd0, dm_if.dm_load_done_o, dm_if.dm_store_done_o}, 32'd0);
        end else begin
          d = done_q.pop_front();
          checkOutput("done_kind", {30'd0, dm_if.dm_load_done_o, dm_if.dm_store_done_o},
                      d.is_load ? 32'd2 : 32'd1);
          if (d.is_load) checkOutput("load_data", dm_if.dm_data_l_o, d.data);
          checkOutput("done_err", {31'd0, dm_if.bus_err_o}, {31'd0, d.err});
        end
      end
    end
  end

  // Bus request monitor: checks each new transfer on its first request cycle.
  initial begin
    txn_t t;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      tick();
      if (rst_i === 1'b1 && dm_if.bus_req_o && !prev_req) begin
        if (txn_q.size() == 0) begin
          checkOutput("unexpected_req", {31'd0, dm_if.bus_req_o}, 32'd0);
        end else begin
          t = txn_q.pop_front();
          checkOutput("bus_we", {31'd0, dm_if.bus_we_o}, {31'd0, t.we});
          checkOutput("bus_addr", {2'd0, dm_if.bus_addr_o}, {2'd0, t.addr});
          checkOutput("bus_be", {28'd0, dm_if.bus_be_o}, {28'd0, t.be});
          checkOutput("bus_wdata", dm_if.bus_wdata_o, t.wdata);
        end
      end
      prev_req = (rst_i === 1'b1) ? dm_if.bus_req_o : 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i                  = 1'b0;
    dm_if.dm_load_i        = 1'b0;
    dm_if.dm_store_i       = 1'b0;
    dm_if.dm_addr_i        = '0;
    dm_if.dm_data_s_i      = '0;
    dm_if.dm_data_select_i = '0;
    dm_if.bus_ack_i        = 1'b0;
    dm_if.bus_rdata_i      = '0;

    // Reset state.
    tick();
    checkOutput("rst_ready", {31'd0, dm_if.dm_ready_o}, 32'd1);
    checkOutput("rst_req", {31'd0, dm_if.bus_req_o}, 32'd0);
    checkOutput("rst_err", {31'd0, dm_if.bus_err_o}, 32'd0);
    checkOutput("rst_data_l", dm_if.dm_data_l_o, 32'd0);
    checkOutput("rst_addr", {2'd0, dm_if.bus_addr_o}, 32'd0);
    rst_i = 1'b1;
    tick();

    // Zero-wait load of 0x1004.
    checkOutput("s1_ready", {31'd0, dm_if.dm_ready_o}, 32'd1);
    txn_q.push_back('{1'b0, 30'h401, 4'hF, 32'h0});
    done_q.push_back('{1'b1, 32'hCAFEBABE, 1'b0});
    dm_if.bus_ack_i   = 1'b1;
    dm_if.bus_rdata_i = 32'hCAFEBABE;
    applyStimulus(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF);
    checkOutput("s1_req_n1", {31'd0, dm_if.bus_req_o}, 32'd1);
    checkOutput("s1_addr_n1", {2'd0, dm_if.bus_addr_o}, 32'h401);
    checkOutput("s1_busy_n1", {31'd0, dm_if.dm_ready_o}, 32'd0);
    tick();
    checkOutput("s1_done_n2", {31'd0, dm_if.dm_load_done_o}, 32'd1);
    checkOutput("s1_data_n2", dm_if.dm_data_l_o, 32'hCAFEBABE);
    checkOutput("s1_ready_n2", {31'd0, dm_if.dm_ready_o}, 32'd1);
    tick();
    checkOutput("s1_ack_ignored", {31'd0, dm_if.bus_req_o}, 32'd0);
    checkOutput("s1_data_held", dm_if.dm_data_l_o, 32'hCAFEBABE);
    dm_if.bus_ack_i = 1'b0;
    tick();

    // Store 0x2002 with three wait cycles.
    txn_q.push_back('{1'b1, 30'h800, 4'b1100, 32'h11223344});
    done_q.push_back('{1'b0, 32'h0, 1'b0});
    applyStimulus(1'b0, 1'b1, 32'h0000_2002, 32'h11223344, 4'b1100);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("s2_req", {31'd0, dm_if.bus_req_o}, 32'd1);
      checkOutput("s2_be_stable", {28'd0, dm_if.bus_be_o}, 32'hC);
      checkOutput("s2_wdata_stable", dm_if.bus_wdata_o, 32'h11223344);
      checkOutput("s2_busy", {31'd0, dm_if.dm_ready_o}, 32'd0);
      checkOutput("s2_store_done", {31'd0, dm_if.dm_store_done_o},
                  (wbuf && i == 1) ? 32'd1 : 32'd0);
      if (i == 4) dm_if.bus_ack_i = 1'b1;
      tick();
    end
    dm_if.bus_ack_i = 1'b0;
    checkOutput("s2_store_done_end", {31'd0, dm_if.dm_store_done_o}, wbuf ? 32'd0 : 32'd1);
    checkOutput("s2_ready_end", {31'd0, dm_if.dm_ready_o}, 32'd1);
    checkOutput("s2_req_end", {31'd0, dm_if.bus_req_o}, 32'd0);
    tick();

    // Load and store together: the store wins.
    txn_q.push_back('{1'b1, 30'hC02, 4'hF, 32'hA5A50F0F});
    done_q.push_back('{1'b0, 32'h0, 1'b0});
    applyStimulus(1'b1, 1'b1, 32'h0000_3008, 32'hA5A50F0F, 4'hF);
    dm_if.bus_ack_i = 1'b1;
    checkOutput("s3_we", {31'd0, dm_if.bus_we_o}, 32'd1);
    checkOutput("s3_early_done", {31'd0, dm_if.dm_store_done_o}, wbuf ? 32'd1 : 32'd0);
    tick();
    dm_if.bus_ack_i = 1'b0;
    checkOutput("s3_store_done", {31'd0, dm_if.dm_store_done_o}, wbuf ? 32'd0 : 32'd1);
    checkOutput("s3_no_load_done", {31'd0, dm_if.dm_load_done_o}, 32'd0);
    tick();

    // Load timeout after four request cycles.
    txn_q.push_back('{1'b0, 30'h1000, 4'hF, 32'h0});
    done_q.push_back('{1'b1, 32'hFFFFFFFF, 1'b1});
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("s4_req", {31'd0, dm_if.bus_req_o}, 32'd1);
      checkOutput("s4_err_low", {31'd0, dm_if.bus_err_o}, 32'd0);
      tick();
    end
    checkOutput("s4_req_dropped", {31'd0, dm_if.bus_req_o}, 32'd0);
    checkOutput("s4_load_done", {31'd0, dm_if.dm_load_done_o}, 32'd1);
    checkOutput("s4_data_ones", dm_if.dm_data_l_o, 32'hFFFFFFFF);
    checkOutput("s4_err_set", {31'd0, dm_if.bus_err_o}, 32'd1);
    tick();
    tick();
    checkOutput("s4_err_sticky", {31'd0, dm_if.bus_err_o}, 32'd1);
    checkOutput("s4_data_held", dm_if.dm_data_l_o, 32'hFFFFFFFF);

    // Reset in the middle of a read.
    txn_q.push_back('{1'b0, 30'h1400, 4'hF, 32'h0});
    applyStimulus(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
    checkOutput("s6_req_before", {31'd0, dm_if.bus_req_o}, 32'd1);
    tick();
    #2 rst_i = 1'b0;
    #1;
    checkOutput("s6_req_async", {31'd0, dm_if.bus_req_o}, 32'd0);
    checkOutput("s6_ready_async", {31'd0, dm_if.dm_ready_o}, 32'd1);
    checkOutput("s6_err_cleared", {31'd0, dm_if.bus_err_o}, 32'd0);
    checkOutput("s6_data_cleared", dm_if.dm_data_l_o, 32'd0);
    tick();
    rst_i = 1'b1;
    tick();
    checkOutput("s6_no_done", {31'd0, dm_if.dm_load_done_o}, 32'd0);
    txn_q.push_back('{1'b0, 30'h1801, 4'hF, 32'h0});
    done_q.push_back('{1'b1, 32'h0BADF00D, 1'b0});
    dm_if.bus_ack_i   = 1'b1;
    dm_if.bus_rdata_i = 32'h0BADF00D;
    applyStimulus(1'b1, 1'b0, 32'h0000_6004, 32'h0, 4'hF);
    checkOutput("s6_next_addr", {2'd0, dm_if.bus_addr_o}, 32'h1801);
    tick();
    dm_if.bus_ack_i = 1'b0;
    checkOutput("s6_next_done", {31'd0, dm_if.dm_load_done_o}, 32'd1);
    checkOutput("s6_next_data", dm_if.dm_data_l_o, 32'h0BADF00D);
    tick();

    // Ack on the fourth request cycle beats the timeout, then back-to-back.
    txn_q.push_back('{1'b0, 30'h1C04, 4'hF, 32'h0});
    done_q.push_back('{1'b1, 32'h5A5AA5A5, 1'b0});
    dm_if.bus_rdata_i = 32'h5A5AA5A5;
    applyStimulus(1'b1, 1'b0, 32'h0000_7010, 32'h0, 4'hF);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("s5_req", {31'd0, dm_if.bus_req_o}, 32'd1);
      if (i == 4) dm_if.bus_ack_i = 1'b1;
      tick();
    end
    checkOutput("s5_done", {31'd0, dm_if.dm_load_done_o}, 32'd1);
    checkOutput("s5_data", dm_if.dm_data_l_o, 32'h5A5AA5A5);
    checkOutput("s5_no_err", {31'd0, dm_if.bus_err_o}, 32'd0);
    checkOutput("s5_ready", {31'd0, dm_if.dm_ready_o}, 32'd1);
    txn_q.push_back('{1'b0, 30'h2000, 4'hF, 32'h0});
    done_q.push_back('{1'b1, 32'h13579BDF, 1'b0});
    dm_if.bus_rdata_i = 32'h13579BDF;
    applyStimulus(1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'hF);
    checkOutput("b2b_req", {31'd0, dm_if.bus_req_o}, 32'd1);
    checkOutput("b2b_addr", {2'd0, dm_if.bus_addr_o}, 32'h2000);
    tick();
    dm_if.bus_ack_i = 1'b0;
    checkOutput("b2b_done", {31'd0, dm_if.dm_load_done_o}, 32'd1);
    checkOutput("b2b_data", dm_if.dm_data_l_o, 32'h13579BDF);
    tick();

    // Store timeout.
    txn_q.push_back('{1'b1, 30'h2400, 4'b0011, 32'hDEADBEEF});
    done_q.push_back('{1'b0, 32'h0, wbuf ? 1'b0 : 1'b1});
    applyStimulus(1'b0, 1'b1, 32'h0000_9000, 32'hDEADBEEF, 4'b0011);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("s7_req", {31'd0, dm_if.bus_req_o}, 32'd1);
      tick();
    end
    checkOutput("s7_req_dropped", {31'd0, dm_if.bus_req_o}, 32'd0);
    checkOutput("s7_err", {31'd0, dm_if.bus_err_o}, 32'd1);
    checkOutput("s7_store_done", {31'd0, dm_if.dm_store_done_o}, wbuf ? 32'd0 : 32'd1);
    checkOutput("s7_ready", {31'd0, dm_if.dm_ready_o}, 32'd1);
    tick();
    tick();

    checkOutput("done_queue_empty", 32'(done_q.size()), 32'd0);
    checkOutput("txn_queue_empty", 32'(txn_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
